// File: rtl/seq_mag_comp.sv
// ---------------------------------------------------------------------------
// seq_mag_comp
//
// Bit-serial magnitude comparator. Two W-bit operands are compared MSB-first,
// one bit per clock, and the scan stops at the first bit where they differ.
// Supports unsigned and two's-complement compare, plus one predicate output
// chosen from EQ / GT / LT / GE.
//
// Handshake: start is accepted on any rising edge where busy=0. x, y,
// signed_en and mode are captured on that same edge. done is a one-cycle
// pulse and the result appears together with it. busy is already low in the
// done cycle, so a new start may be presented there. There is no
// backpressure. gt/eq/lt/z hold the last result until the next done.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active-high
//   start      compare request, ignored while busy=1
//   x, y       operands A and B, W bits each
//   signed_en  1 = two's-complement compare, 0 = unsigned
//   mode       predicate select: 00 EQ, 01 GT, 10 LT, 11 GE
//   busy       high while a compare is being scanned
//   done       one-cycle pulse, result valid
//   gt/eq/lt   registered relation of x to y
//   z          registered selected predicate
//
// The FSM state is held in the signal "state" (type state_t) so that
// checkers can bind to it.
// ---------------------------------------------------------------------------
module seq_mag_comp #(
    parameter int W    = 8,
    parameter int IDXW = $clog2(W)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         signed_en,
    input  logic [1:0]   mode,
    output logic         busy,
    output logic         done,
    output logic         gt,
    output logic         eq,
    output logic         lt,
    output logic         z
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    localparam logic [IDXW-1:0] IDX_MSB = IDXW'(W - 1);

    state_t          state, state_nx;
    logic [W-1:0]    xa, xa_nx;
    logic [W-1:0]    ya, ya_nx;
    logic            sgn, sgn_nx;
    logic [1:0]      md, md_nx;
    logic [IDXW-1:0] idx, idx_nx;
    logic            done_nx, gt_nx, eq_nx, lt_nx, z_nx;

    logic            bit_x, bit_y;
    logic            x_wins;

    // Predicate select applied to a freshly computed relation.
    function automatic logic pick(input logic [1:0] m, input logic g,
                                  input logic e, input logic l);
        case (m)
            2'b00:   pick = e;
            2'b01:   pick = g;
            2'b10:   pick = l;
            default: pick = g | e;
        endcase
    endfunction

    assign busy = (state == SCAN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            xa    <= '0;
            ya    <= '0;
            sgn   <= 1'b0;
            md    <= 2'b00;
            idx   <= '0;
            done  <= 1'b0;
            gt    <= 1'b0;
            eq    <= 1'b0;
            lt    <= 1'b0;
            z     <= 1'b0;
        end else begin
            state <= state_nx;
            xa    <= xa_nx;
            ya    <= ya_nx;
            sgn   <= sgn_nx;
            md    <= md_nx;
            idx   <= idx_nx;
            done  <= done_nx;
            gt    <= gt_nx;
            eq    <= eq_nx;
            lt    <= lt_nx;
            z     <= z_nx;
        end
    end

    always_comb begin
        state_nx = state;
        xa_nx    = xa;
        ya_nx    = ya;
        sgn_nx   = sgn;
        md_nx    = md;
        idx_nx   = idx;
        done_nx  = 1'b0;  // done only ever lasts one cycle
        gt_nx    = gt;
        eq_nx    = eq;
        lt_nx    = lt;
        z_nx     = z;

        bit_x = xa[idx];
        bit_y = ya[idx];
        // A differing sign bit means the operand with the 1 is negative,
        // so in signed mode the winner at the MSB is the one holding a 0.
        x_wins = (sgn && (idx == IDX_MSB)) ? bit_y : bit_x;

        case (state)
            IDLE: begin
                if (start) begin
                    xa_nx    = x;
                    ya_nx    = y;
                    sgn_nx   = signed_en;
                    md_nx    = mode;
                    idx_nx   = IDX_MSB;
                    state_nx = SCAN;
                end
            end
            SCAN: begin
                if (bit_x != bit_y) begin
                    gt_nx    = x_wins;
                    lt_nx    = ~x_wins;
                    eq_nx    = 1'b0;
                    z_nx     = pick(md, x_wins, 1'b0, ~x_wins);
                    done_nx  = 1'b1;
                    state_nx = IDLE;
                end else if (idx == '0) begin
                    gt_nx    = 1'b0;
                    lt_nx    = 1'b0;
                    eq_nx    = 1'b1;
                    z_nx     = pick(md, 1'b0, 1'b1, 1'b0);
                    done_nx  = 1'b1;
                    state_nx = IDLE;
                end else begin
                    idx_nx = idx - 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_seq_mag_comp.sv
// ---------------------------------------------------------------------------
// Bench for seq_mag_comp: an 8-bit instance checked every cycle against an
// arithmetic reference model, plus a 2-bit instance swept over all inputs.
// ---------------------------------------------------------------------------
module tb_seq_mag_comp;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       sgn = 1'b0;
  logic [1:0] md  = 2'b00;

  logic       start8 = 1'b0;
  logic [7:0] x8 = '0, y8 = '0;
  logic       busy8, done8, gt8, eq8, lt8, z8;

  logic       start2 = 1'b0;
  logic [1:0] x2 = '0, y2 = '0;
  logic       busy2, done2, gt2, eq2, lt2, z2;

  seq_mag_comp #(.W(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .x(x8), .y(y8),
    .signed_en(sgn), .mode(md), .busy(busy8), .done(done8),
    .gt(gt8), .eq(eq8), .lt(lt8), .z(z8)
  );

  seq_mag_comp #(.W(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .x(x2), .y(y2),
    .signed_en(sgn), .mode(md), .busy(busy2), .done(done2),
    .gt(gt2), .eq(eq2), .lt(lt2), .z(z2)
  );

  // ---------------- counters / check ----------------
  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model (arithmetic) ----------------
  // Returns {gt, eq, lt} from the numeric values of the operands.
  function automatic logic [2:0] ref_cmp(input logic [7:0] a, input logic [7:0] b,
                                         input logic s, input int w);
    int va, vb;
    va = int'(a) & ((1 << w) - 1);
    vb = int'(b) & ((1 << w) - 1);
    if (s && va >= (1 << (w - 1))) va -= (1 << w);
    if (s && vb >= (1 << (w - 1))) vb -= (1 << w);
    return {va > vb, va == vb, va < vb};
  endfunction

  function automatic logic ref_z(input logic [2:0] r, input logic [1:0] m);
    case (m)
      2'b00:   return r[1];
      2'b01:   return r[2];
      2'b10:   return r[0];
      default: return r[2] | r[1];
    endcase
  endfunction

  // Edges after the accepting edge until done: W - (first differing bit).
  function automatic int ref_lat(input logic [7:0] a, input logic [7:0] b, input int w);
    for (int i = w - 1; i >= 0; i--)
      if (a[i] != b[i]) return w - i;
    return w;
  endfunction

  // ---------------- model of the 8-bit instance ----------------
  int         m_cnt;   // edges left until done, 0 = idle
  logic       m_done;
  logic [2:0] m_res, p_res;
  logic       m_z, p_z;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt = 0; m_done = 1'b0; m_res = 3'b000; m_z = 1'b0;
      p_res = 3'b000; p_z = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_done = 1'b1; m_res = p_res; m_z = p_z;
        end
      end else if (start8) begin
        m_cnt = ref_lat(x8, y8, 8);
        p_res = ref_cmp(x8, y8, sgn, 8);
        p_z   = ref_z(p_res, md);
      end
    end
  end

  // ---------------- scoreboard: every-cycle compare ----------------
  always @(negedge clk) begin
    check("busy", {7'd0, busy8}, {7'd0, (m_cnt > 0)});
    check("done", {7'd0, done8}, {7'd0, m_done});
    check("gt_eq_lt", {5'd0, gt8, eq8, lt8}, {5'd0, m_res});
    check("z", {7'd0, z8}, {7'd0, m_z});
  end

  // ---------------- driver tasks ----------------
  // now=1: present start in the current cycle (already at a negedge).
  task automatic go8(input logic [7:0] a, input logic [7:0] b, input logic s,
                     input logic [1:0] m, input bit now, output int lat);
    if (!now) @(negedge clk);
    x8 = a; y8 = b; sgn = s; md = m; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); lat++;
      @(negedge clk);
    end while (!done8 && lat < 20);
    if (!done8) check("timeout8", 8'd0, 8'd1);
  endtask

  task automatic go2(input logic [1:0] a, input logic [1:0] b, input logic s,
                     input logic [1:0] m);
    int lat;
    logic [2:0] r;
    @(negedge clk);
    x2 = a; y2 = b; sgn = s; md = m; start2 = 1'b1;
    @(posedge clk);
    #1 start2 = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); lat++;
      @(negedge clk);
    end while (!done2 && lat < 10);
    r = ref_cmp({6'd0, a}, {6'd0, b}, s, 2);
    check("w2_lat", lat[7:0], ref_lat({6'd0, a}, {6'd0, b}, 2) > 0 ?
                              8'(ref_lat({6'd0, a}, {6'd0, b}, 2)) : 8'd0);
    check("w2_res", {5'd0, gt2, eq2, lt2}, {5'd0, r});
    check("w2_z", {7'd0, z2}, {7'd0, ref_z(r, m)});
    check("w2_busy", {7'd0, busy2}, 8'd0);
  endtask

  // ---------------- directed tests ----------------
  int lat;
  int n_done;

  initial begin
    #1;
    check("rst_outs", {3'd0, busy8, done8, gt8, eq8, lt8}, 8'd0);
    check("rst_z", {7'd0, z8}, 8'd0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;

    // Model pinned to hand values.
    check("ref_ff01_s", {5'd0, ref_cmp(8'hFF, 8'h01, 1'b1, 8)}, 8'b001);
    check("ref_ff01_u", {5'd0, ref_cmp(8'hFF, 8'h01, 1'b0, 8)}, 8'b100);
    check("ref_lat_100f", 8'(ref_lat(8'h10, 8'h0F, 8)), 8'd4);

    // Reset mid-scan: first difference at bit 4, so done would be at edge 4.
    @(negedge clk);
    x8 = 8'h10; y8 = 8'h0F; sgn = 1'b0; md = 2'b01; start8 = 1'b1;
    @(posedge clk);          // edge 0
    #1 start8 = 1'b0;
    @(posedge clk);          // edge 1
    #2 rst = 1'b1;
    #1;
    check("midrst_outs", {2'd0, busy8, done8, gt8, eq8, lt8, z8}, 8'd0);
    @(negedge clk);
    #1 rst = 1'b0;
    n_done = 0;
    repeat (10) begin
      @(negedge clk);
      if (done8) n_done++;
    end
    check("midrst_nodone", 8'(n_done), 8'd0);

    // Early exit at MSB.
    go8(8'h80, 8'h7F, 1'b0, 2'b01, 1'b0, lat);
    check("msb_lat", 8'(lat), 8'd1);
    check("msb_res", {4'd0, gt8, eq8, lt8, z8}, 8'b1001);
    check("msb_busy", {7'd0, busy8}, 8'd0);

    // Equal operands, full scan, EQ then GE.
    go8(8'hA5, 8'hA5, 1'b0, 2'b00, 1'b0, lat);
    check("eq_lat", 8'(lat), 8'd8);
    check("eq_res", {4'd0, gt8, eq8, lt8, z8}, 8'b0101);
    go8(8'hA5, 8'hA5, 1'b0, 2'b11, 1'b0, lat);
    check("ge_z", {7'd0, z8}, 8'd1);

    // Signed vs unsigned.
    go8(8'hFF, 8'h01, 1'b1, 2'b10, 1'b0, lat);
    check("s_lat", 8'(lat), 8'd1);
    check("s_res", {4'd0, gt8, eq8, lt8, z8}, 8'b0011);
    go8(8'hFF, 8'h01, 1'b0, 2'b10, 1'b0, lat);
    check("u_res", {4'd0, gt8, eq8, lt8, z8}, 8'b1000);

    // Late difference with ignored mid-scan start, then back-to-back.
    @(negedge clk);
    x8 = 8'h04; y8 = 8'h05; sgn = 1'b0; md = 2'b10; start8 = 1'b1;
    @(posedge clk);          // edge 0
    #1 start8 = 1'b0;
    @(posedge clk);          // edge 1
    @(posedge clk);          // edge 2
    #1 begin start8 = 1'b1; x8 = 8'h00; md = 2'b00; end
    @(posedge clk);          // edge 3, must be ignored
    #1 start8 = 1'b0;
    lat = 3;
    do begin
      @(posedge clk); lat++;
      @(negedge clk);
    end while (!done8 && lat < 20);
    check("late_lat", 8'(lat), 8'd8);
    check("late_res", {4'd0, gt8, eq8, lt8, z8}, 8'b0011);
    go8(8'h01, 8'h00, 1'b0, 2'b01, 1'b1, lat);
    check("b2b_lat", 8'(lat), 8'd8);
    check("b2b_res", {4'd0, gt8, eq8, lt8, z8}, 8'b1001);

    // Outputs hold in idle.
    repeat (3) @(negedge clk);
    check("hold_res", {4'd0, gt8, eq8, lt8, z8}, 8'b1001);

    // A few more patterns through the model.
    go8(8'h7F, 8'h80, 1'b1, 2'b01, 1'b0, lat);
    check("s7f80_gt", {7'd0, gt8}, 8'd1);
    go8(8'h3C, 8'h3D, 1'b1, 2'b11, 1'b0, lat);
    check("s3c3d_ge", {7'd0, z8}, 8'd0);

    // Exhaustive 2-bit sweep.
    for (int s = 0; s < 2; s++)
      for (int m = 0; m < 4; m++)
        for (int a = 0; a < 4; a++)
          for (int b = 0; b < 4; b++)
            go2(2'(a), 2'(b), 1'(s), 2'(m));

    repeat (2) @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
